// File: rtl/fetch_prefetch_unit_if.sv
// Fetch unit bus bundle: burst-read port toward unified memory plus the decode-side handshake.
interface fetch_prefetch_unit_if;
    logic [31:0] mem_addr;
    logic [1:0]  mem_access_size;
    logic        mem_rd_wr;
    logic        mem_enable;
    logic [31:0] mem_rdata;
    logic        mem_busy;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] pc_out;

    modport master (
        output mem_addr, mem_access_size, mem_rd_wr, mem_enable,
        input  mem_rdata, mem_busy,
        input  redirect, redirect_pc,
        output instr_valid, instr_out, pc_out,
        input  instr_ready
    );

    modport slave (
        input  mem_addr, mem_access_size, mem_rd_wr, mem_enable,
        output mem_rdata, mem_busy,
        output redirect, redirect_pc,
        input  instr_valid, instr_out, pc_out,
        output instr_ready
    );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: 4-word read bursts into an instruction FIFO feeding decode.
// Optional FETCH_PERF_EN adds saturating burst/flush/stall counters.
module fetch_prefetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h8002_0000,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fetch_prefetch_unit_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]           perf_bursts,
    output logic [31:0]           perf_flushes,
    output logic [31:0]           perf_stalls
`endif
);
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam int unsigned BURST_LEN = 4;
    localparam int unsigned LAST_CYC  = RD_LATENCY + BURST_LEN - 1;
    localparam int unsigned CYC_W     = $clog2(LAST_CYC + 1);
    localparam logic [1:0]  SZ_4WORD  = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RECV, S_DRAIN} state_e;

    state_e            state_q, state_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic              mem_enable_q, mem_enable_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       instr_mem_q [FIFO_DEPTH];
    logic [31:0]       pc_mem_q    [FIFO_DEPTH];
    logic              instr_valid_q, instr_valid_d;
    logic [31:0]       instr_out_q, instr_out_d, pc_out_q, pc_out_d;
    logic              push, pop;
    logic [1:0]        word_idx;
    logic [31:0]       push_pc;
    logic              unused_pc_lsbs;

    assign unused_pc_lsbs = ^bus.redirect_pc[1:0];

    // Cycle counter runs from 1 after burst acceptance; word k lands at cycle RD_LATENCY+k.
    assign word_idx = 2'(cyc_q - CYC_W'(RD_LATENCY));
    assign push_pc  = mem_addr_q + {28'd0, word_idx, 2'b00};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_addr_d = mem_addr_q;
        cyc_d      = cyc_q;
        push       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!bus.redirect && ((CNT_W'(FIFO_DEPTH) - count_q) >= CNT_W'(BURST_LEN))) begin
                    state_d    = S_REQ;
                    mem_addr_d = fetch_pc_q;
                end
            end
            S_REQ: begin
                if (!bus.mem_busy) begin
                    cyc_d = CYC_W'(1);
                    if (bus.redirect)        state_d = S_DRAIN;
                    else if (RD_LATENCY > 1) state_d = S_WAIT;
                    else                     state_d = S_RECV;
                end else if (bus.redirect) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                cyc_d = cyc_q + CYC_W'(1);
                if (bus.redirect)                            state_d = S_DRAIN;
                else if (cyc_q == CYC_W'(RD_LATENCY - 1))   state_d = S_RECV;
            end
            S_RECV: begin
                cyc_d = cyc_q + CYC_W'(1);
                push  = !bus.redirect;
                if (cyc_q == CYC_W'(LAST_CYC)) begin
                    state_d    = S_IDLE;
                    fetch_pc_d = fetch_pc_q + 32'd16;
                end else if (bus.redirect) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                cyc_d = cyc_q + CYC_W'(1);
                if (cyc_q == CYC_W'(LAST_CYC)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.redirect) fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
        mem_enable_d = (state_d != S_IDLE);
    end

    // FIFO bookkeeping; the head register is preloaded with whatever sits at the next read pointer.
    always_comb begin
        pop      = instr_valid_q && bus.instr_ready && !bus.redirect;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
        instr_valid_d = (count_d != '0);
        instr_out_d   = instr_out_q;
        pc_out_d      = pc_out_q;
        if (instr_valid_d) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                instr_out_d = bus.mem_rdata;
                pc_out_d    = push_pc;
            end else begin
                instr_out_d = instr_mem_q[rd_ptr_d];
                pc_out_d    = pc_mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            fetch_pc_q    <= RESET_PC;
            mem_addr_q    <= RESET_PC;
            mem_enable_q  <= 1'b0;
            cyc_q         <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            instr_valid_q <= 1'b0;
            instr_out_q   <= '0;
            pc_out_q      <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            mem_addr_q    <= mem_addr_d;
            mem_enable_q  <= mem_enable_d;
            cyc_q         <= cyc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            instr_valid_q <= instr_valid_d;
            instr_out_q   <= instr_out_d;
            pc_out_q      <= pc_out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= bus.mem_rdata;
            pc_mem_q[wr_ptr_q]    <= push_pc;
        end
    end

    assign bus.mem_addr        = mem_addr_q;
    assign bus.mem_access_size = SZ_4WORD;
    assign bus.mem_rd_wr       = 1'b1;
    assign bus.mem_enable      = mem_enable_q;
    assign bus.instr_valid     = instr_valid_q;
    assign bus.instr_out       = instr_out_q;
    assign bus.pc_out          = pc_out_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_bursts_q, perf_flushes_q, perf_stalls_q;
    logic        burst_issue;

    assign burst_issue = (state_q == S_REQ) && !bus.mem_busy;

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_bursts_q  <= '0;
            perf_flushes_q <= '0;
            perf_stalls_q  <= '0;
        end else begin
            if (burst_issue && (perf_bursts_q != '1))    perf_bursts_q  <= perf_bursts_q + 32'd1;
            if (bus.redirect && (perf_flushes_q != '1))  perf_flushes_q <= perf_flushes_q + 32'd1;
            if (!instr_valid_q && (perf_stalls_q != '1)) perf_stalls_q  <= perf_stalls_q + 32'd1;
        end
    end

    assign perf_bursts  = perf_bursts_q;
    assign perf_flushes = perf_flushes_q;
    assign perf_stalls  = perf_stalls_q;
`endif
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with a burst-memory responder and a decode-side recorder.
module tb_fetch_prefetch_unit;
    localparam logic [31:0] RESET_PC = 32'h8002_0000;
    localparam logic [1:0]  SZ_4WORD = 2'b10;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    fetch_prefetch_unit_if bus();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_bursts, perf_flushes, perf_stalls;
`endif

    fetch_prefetch_unit #(
        .RESET_PC  (RESET_PC),
        .FIFO_DEPTH(8),
        .RD_LATENCY(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_bursts (perf_bursts),
        .perf_flushes(perf_flushes),
        .perf_stalls (perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    // Memory responder and decode recorder, both evaluated mid-cycle on the falling edge.
    logic [31:0] m_base;
    int          m_cnt;
    bit          m_burst;
    bit          m_was;
    int          cur_word;
    logic [31:0] req_addr[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_instr[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            m_burst       = 1'b0;
            m_cnt         = 0;
            cur_word      = -1;
            bus.mem_rdata = 32'hDEAD_BEEF;
        end else begin
            m_was = m_burst;
            if (m_burst) begin
                cur_word      = m_cnt;
                bus.mem_rdata = ~(m_base + 32'(4 * m_cnt));
                if (m_cnt == 3) m_burst = 1'b0;
                else            m_cnt   = m_cnt + 1;
            end else begin
                cur_word      = -1;
                bus.mem_rdata = 32'hDEAD_BEEF;
            end
            if (!m_was && bus.mem_enable && !bus.mem_busy) begin
                m_burst = 1'b1;
                m_cnt   = 0;
                m_base  = bus.mem_addr;
                req_addr.push_back(bus.mem_addr);
            end
            if (bus.instr_valid && bus.instr_ready && !bus.redirect) begin
                got_pc.push_back(bus.pc_out);
                got_instr.push_back(bus.instr_out);
            end
        end
    end

    task automatic apply_reset();
        rst_n           = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.mem_busy    = 1'b0;
        bus.instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        req_addr.delete();
        got_pc.delete();
        got_instr.delete();
    endtask

    task automatic release_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic wait_got(input int n, input int budget, output bit ok);
        for (int i = 0; i < budget; i++) begin
            if (got_pc.size() >= n) break;
            @(negedge clk);
            #1;
        end
        ok = (got_pc.size() >= n);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (bus.mem_enable !== 1'b0) begin errors++; $display("FAIL reset_mem_enable got %0b exp 0", bus.mem_enable); end
        checks++;
        if (bus.mem_addr !== RESET_PC) begin errors++; $display("FAIL reset_mem_addr got %h exp %h", bus.mem_addr, RESET_PC); end
        checks++;
        if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid got %0b exp 0", bus.instr_valid); end
        checks++;
        if (bus.instr_out !== 32'h0) begin errors++; $display("FAIL reset_instr_out got %h exp 0", bus.instr_out); end
        checks++;
        if (bus.pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc_out got %h exp 0", bus.pc_out); end
        checks++;
        if (bus.mem_rd_wr !== 1'b1 || bus.mem_access_size !== SZ_4WORD) begin
            errors++; $display("FAIL reset_mem_ctrl got rd_wr=%0b size=%0b exp 1/%0b", bus.mem_rd_wr, bus.mem_access_size, SZ_4WORD);
        end
    endtask

    task automatic test_basic_stream();
        bit ok;
        logic [31:0] exp_pc;
        apply_reset();
        bus.instr_ready = 1'b1;
        release_reset();
        wait_got(8, 80, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_timeout got %0d words exp 8", got_pc.size()); end
        checks++;
        if (req_addr.size() < 2 || req_addr[0] !== RESET_PC || req_addr[1] !== RESET_PC + 32'h10) begin
            errors++; $display("FAIL basic_req_addrs got n=%0d first=%h exp %h then %h", req_addr.size(),
                               (req_addr.size() > 0) ? req_addr[0] : 32'hx, RESET_PC, RESET_PC + 32'h10);
        end
        for (int k = 0; k < 8; k++) begin
            exp_pc = RESET_PC + 32'(4 * k);
            checks++;
            if (got_pc.size() <= k || got_pc[k] !== exp_pc || got_instr[k] !== ~exp_pc) begin
                errors++; $display("FAIL basic_word%0d got pc=%h instr=%h exp pc=%h instr=%h", k,
                                   (got_pc.size() > k) ? got_pc[k] : 32'hx, (got_pc.size() > k) ? got_instr[k] : 32'hx,
                                   exp_pc, ~exp_pc);
            end
        end
    endtask

    task automatic test_stall();
        bit ok;
        bit unstable = 1'b0;
        logic [31:0] exp_pc;
        apply_reset();
        release_reset();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (bus.instr_valid && (bus.pc_out !== RESET_PC || bus.instr_out !== ~RESET_PC)) unstable = 1'b1;
        end
        checks++;
        if (unstable) begin errors++; $display("FAIL stall_head_stable got changing head exp pc %h held", RESET_PC); end
        checks++;
        if (req_addr.size() != 2) begin errors++; $display("FAIL stall_burst_count got %0d exp 2", req_addr.size()); end
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.pc_out !== RESET_PC) begin
            errors++; $display("FAIL stall_head got valid=%0b pc=%h exp 1/%h", bus.instr_valid, bus.pc_out, RESET_PC);
        end
        checks++;
        if (bus.mem_enable !== 1'b0) begin errors++; $display("FAIL stall_no_req got enable=%0b exp 0", bus.mem_enable); end
        @(posedge clk);
        #1;
        bus.instr_ready = 1'b1;
        wait_got(8, 60, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stall_drain_timeout got %0d words exp 8", got_pc.size()); end
        for (int k = 0; k < 8; k++) begin
            exp_pc = RESET_PC + 32'(4 * k);
            checks++;
            if (got_pc.size() <= k || got_pc[k] !== exp_pc || got_instr[k] !== ~exp_pc) begin
                errors++; $display("FAIL stall_word%0d got pc=%h exp pc=%h", k,
                                   (got_pc.size() > k) ? got_pc[k] : 32'hx, exp_pc);
            end
        end
    endtask

    task automatic test_redirect();
        bit ok;
        bit found = 1'b0;
        logic [31:0] exp_pc;
        apply_reset();
        bus.instr_ready = 1'b1;
        release_reset();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (cur_word == 0) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL redir_no_burst got none exp word0 within 40 cycles"); end
        @(posedge clk);
        #1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h8002_0103;
        @(posedge clk);
        #1;
        bus.redirect = 1'b0;
        checks++;
        if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got valid=%0b exp 0", bus.instr_valid); end
        checks++;
        if (bus.mem_enable !== 1'b1) begin errors++; $display("FAIL redir_drain_enable got %0b exp 1", bus.mem_enable); end
        wait_got(1, 40, ok);
`ifdef FETCH_PERF_EN
        checks++;
        if (perf_flushes !== 32'd1 || perf_bursts !== 32'd2) begin
            errors++; $display("FAIL perf_counts got bursts=%0d flushes=%0d exp 2/1", perf_bursts, perf_flushes);
        end
`endif
        wait_got(4, 40, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL redir_timeout got %0d words exp 4", got_pc.size()); end
        checks++;
        if (req_addr.size() < 2 || req_addr[1] !== 32'h8002_0100) begin
            errors++; $display("FAIL redir_req_addr got %h exp 80020100", (req_addr.size() > 1) ? req_addr[1] : 32'hx);
        end
        for (int k = 0; k < 4; k++) begin
            exp_pc = 32'h8002_0100 + 32'(4 * k);
            checks++;
            if (got_pc.size() <= k || got_pc[k] !== exp_pc || got_instr[k] !== ~exp_pc) begin
                errors++; $display("FAIL redir_word%0d got pc=%h exp pc=%h", k,
                                   (got_pc.size() > k) ? got_pc[k] : 32'hx, exp_pc);
            end
        end
    endtask

    task automatic test_busy();
        bit ok;
        bit found = 1'b0;
        bit held = 1'b1;
        logic [31:0] addr0;
        logic [31:0] exp_pc;
        apply_reset();
        bus.instr_ready = 1'b1;
        bus.mem_busy    = 1'b1;
        release_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (bus.mem_enable) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL busy_no_req got enable=0 exp 1 within 20 cycles"); end
        addr0 = bus.mem_addr;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            if (bus.mem_enable !== 1'b1 || bus.mem_addr !== addr0) held = 1'b0;
        end
        checks++;
        if (!held || addr0 !== RESET_PC) begin
            errors++; $display("FAIL busy_hold got held=%0b addr=%h exp 1/%h", held, addr0, RESET_PC);
        end
        checks++;
        if (req_addr.size() != 0 || got_pc.size() != 0) begin
            errors++; $display("FAIL busy_premature got bursts=%0d words=%0d exp 0/0", req_addr.size(), got_pc.size());
        end
        @(posedge clk);
        #1;
        bus.mem_busy = 1'b0;
        wait_got(4, 40, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL busy_timeout got %0d words exp 4", got_pc.size()); end
        for (int k = 0; k < 4; k++) begin
            exp_pc = RESET_PC + 32'(4 * k);
            checks++;
            if (got_pc.size() <= k || got_pc[k] !== exp_pc || got_instr[k] !== ~exp_pc) begin
                errors++; $display("FAIL busy_word%0d got pc=%h exp pc=%h", k,
                                   (got_pc.size() > k) ? got_pc[k] : 32'hx, exp_pc);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        bit found = 1'b0;
        apply_reset();
        bus.instr_ready = 1'b1;
        release_reset();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (cur_word == 1) begin found = 1'b1; break; end
        end
        checks++;
        if (!found || bus.instr_valid !== 1'b1) begin
            errors++; $display("FAIL midrst_setup got found=%0b valid=%0b exp 1/1", found, bus.instr_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.mem_enable !== 1'b0 || bus.instr_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_ctrl got enable=%0b valid=%0b exp 0/0", bus.mem_enable, bus.instr_valid);
        end
        checks++;
        if (bus.instr_out !== 32'h0 || bus.pc_out !== 32'h0 || bus.mem_addr !== RESET_PC) begin
            errors++; $display("FAIL midrst_data got instr=%h pc=%h addr=%h exp 0/0/%h",
                               bus.instr_out, bus.pc_out, bus.mem_addr, RESET_PC);
        end
        repeat (2) @(negedge clk);
        #1;
        req_addr.delete();
        got_pc.delete();
        got_instr.delete();
        release_reset();
        wait_got(4, 40, ok);
        checks++;
        if (!ok || req_addr.size() < 1 || req_addr[0] !== RESET_PC || got_pc[0] !== RESET_PC || got_pc[3] !== RESET_PC + 32'hC) begin
            errors++; $display("FAIL midrst_restart got words=%0d first_pc=%h exp 4 words from %h", got_pc.size(),
                               (got_pc.size() > 0) ? got_pc[0] : 32'hx, RESET_PC);
        end
    endtask

    initial begin
        test_reset();
        test_basic_stream();
        test_stall();
        test_redirect();
        test_busy();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion exp finish before 200us");
        $fatal(1);
    end
endmodule
